strip_trigger_candidate_buffer: RTL and testbench

STRIP_TRIGGER_CANDIDATE_BUFFER -- requirements
Module: strip_trigger_candidate_buffer

---
 rtl/strip_trigger_candidate_buffer_if.sv | 27 ++
 rtl/strip_trigger_candidate_buffer.sv | 124 ++++++++++++
 tb/tb_strip_trigger_candidate_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/strip_trigger_candidate_buffer_if.sv
// Bundle of candidate-input and serializer-load signals for the strip trigger candidate buffer.
interface strip_trigger_candidate_buffer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    band_id_in;
  logic [11:0]   bcid_in;
  logic          data_ready_in;
  logic          trig_ready;
  logic          load_out;
  logic [7:0]    band_id_out;
  logic [11:0]   bcid_out;
  logic [LW-1:0] fifo_level;
  logic [15:0]   overflow_cnt;
  logic [15:0]   dup_cnt;

  modport slave (
    input  band_id_in, bcid_in, data_ready_in, trig_ready,
    output load_out, band_id_out, bcid_out, fifo_level, overflow_cnt, dup_cnt
  );

  modport master (
    output band_id_in, bcid_in, data_ready_in, trig_ready,
    input  load_out, band_id_out, bcid_out, fifo_level, overflow_cnt, dup_cnt
  );
endinterface

// File: rtl/strip_trigger_candidate_buffer.sv
// Queues strip trigger candidates, drops duplicates/overflow, and issues them to the serializer
// one per phase-3 slot, with a minimum holdoff between loads.
module strip_trigger_candidate_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HOLDOFF = 4
) (
  input logic                            clk,
  input logic                            reset,
  strip_trigger_candidate_buffer_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [7:0] HoldLoad = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {StIdle, StWaitSlot, StHold} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [1:0]    phase_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [19:0]   mem_q [DEPTH];
  logic [19:0]   last_q;
  logic          last_valid_q;
  logic [15:0]   ovf_q, dup_q;
  logic          load_q;
  logic [7:0]    band_q;
  logic [11:0]   bcid_q;

  logic [19:0] cand;
  logic        empty, full, issue, is_dup, push, is_ovf;

  always_comb begin
    cand   = {bus.bcid_in, bus.band_id_in};
    empty  = (level_q == '0);
    full   = (level_q == LW'(DEPTH));
    issue  = (state_q == StWaitSlot) && (phase_q == 2'd3) && !empty && bus.trig_ready;
    is_dup = bus.data_ready_in && last_valid_q && (last_q == cand);
    // A same-edge pop frees a slot, so a full FIFO still accepts when issuing.
    is_ovf = bus.data_ready_in && !is_dup && full && !issue;
    push   = bus.data_ready_in && !is_dup && !is_ovf;
  end

  always_comb begin
    level_d = level_q;
    if (push && !issue) begin
      level_d = level_q + LW'(1);
    end else if (!push && issue) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (level_d != '0) state_d = StWaitSlot;
      end
      StWaitSlot: begin
        if (issue) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end
      end
      StHold: begin
        if (hold_cnt_q <= 8'd1) begin
          state_d = (level_d != '0) ? StWaitSlot : StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_cnt_q   <= '0;
      phase_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      ovf_q        <= '0;
      dup_q        <= '0;
      load_q       <= 1'b0;
      band_q       <= '0;
      bcid_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      phase_q    <= phase_q + 2'd1;
      level_q    <= level_d;
      load_q     <= issue;
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        bcid_q   <= mem_q[rd_ptr_q][19:8];
        band_q   <= mem_q[rd_ptr_q][7:0];
      end
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + AW'(1);
        last_q       <= cand;
        last_valid_q <= 1'b1;
      end
      if (is_dup && dup_q != 16'hFFFF) dup_q <= dup_q + 16'd1;
      if (is_ovf && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cand;
  end

  assign bus.load_out     = load_q;
  assign bus.band_id_out  = band_q;
  assign bus.bcid_out     = bcid_q;
  assign bus.fifo_level   = level_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.dup_cnt      = dup_q;
endmodule

// File: tb/tb_strip_trigger_candidate_buffer.sv
// Directed plus randomized bench for strip_trigger_candidate_buffer against a queue-based model.
module tb_strip_trigger_candidate_buffer;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned HOLDOFF  = 6;
  localparam int          HOLD_EFF = (HOLDOFF < 2) ? 2 : HOLDOFF;
  localparam int          MIN_GAP  = (HOLDOFF > 4) ? HOLDOFF : 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  strip_trigger_candidate_buffer_if #(.DEPTH(DEPTH)) bus ();

  strip_trigger_candidate_buffer #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state
  logic [19:0] mq[$];
  int          edge_n;
  int          last_issue;
  logic [19:0] m_last;
  bit          m_last_v;
  int          m_ovf, m_dup;
  logic        m_load;
  logic [7:0]  m_band;
  logic [11:0] m_bcid;

  int          vectors = 0;
  int          fails   = 0;
  int          cyc_n   = 0;
  logic [19:0] log_q[$];
  int          log_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    edge_n     = 0;
    last_issue = -1000;
    m_last     = '0;
    m_last_v   = 1'b0;
    m_ovf      = 0;
    m_dup      = 0;
    m_load     = 1'b0;
    m_band     = '0;
    m_bcid     = '0;
    log_q.delete();
    log_t.delete();
  endtask

  task automatic chk_all(input string pfx);
    chk({pfx, "load_out"},     32'(bus.load_out),     32'(m_load));
    chk({pfx, "band_id_out"},  32'(bus.band_id_out),  32'(m_band));
    chk({pfx, "bcid_out"},     32'(bus.bcid_out),     32'(m_bcid));
    chk({pfx, "fifo_level"},   32'(bus.fifo_level),   32'(mq.size()));
    chk({pfx, "overflow_cnt"}, 32'(bus.overflow_cnt), 32'(m_ovf));
    chk({pfx, "dup_cnt"},      32'(bus.dup_cnt),      32'(m_dup));
  endtask

  // Drive one cycle of inputs, predict the edge, then compare after it.
  task automatic cyc(input bit dr, input logic [7:0] band, input logic [11:0] bcid,
                     input bit tr);
    logic [19:0] cand, head;
    bit          issue;
    bus.data_ready_in = dr;
    bus.band_id_in    = band;
    bus.bcid_in       = bcid;
    bus.trig_ready    = tr;
    edge_n++;
    cand   = {bcid, band};
    issue  = (edge_n % 4 == 0) && (mq.size() > 0) && tr && (edge_n - last_issue >= HOLD_EFF);
    m_load = 1'b0;
    if (issue) begin
      head       = mq.pop_front();
      m_bcid     = head[19:8];
      m_band     = head[7:0];
      m_load     = 1'b1;
      last_issue = edge_n;
    end
    if (dr) begin
      if (m_last_v && m_last == cand) begin
        if (m_dup < 16'hFFFF) m_dup++;
      end else if (mq.size() >= DEPTH) begin
        if (m_ovf < 16'hFFFF) m_ovf++;
      end else begin
        mq.push_back(cand);
        m_last   = cand;
        m_last_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.load_out) begin
      log_q.push_back({bus.bcid_out, bus.band_id_out});
      log_t.push_back(cyc_n);
    end
    chk_all("");
  endtask

  task automatic idle(input int n, input bit tr);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 12'h000, tr);
  endtask

  task automatic do_reset();
    bus.data_ready_in = 1'b0;
    bus.trig_ready    = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("rst_");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.data_ready_in = 1'b0;
    bus.band_id_in    = '0;
    bus.bcid_in       = '0;
    bus.trig_ready    = 1'b0;
    reset             = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("init_");
    reset = 1'b0;

    // Single candidate issued at the first slot
    cyc(1'b1, 8'h12, 12'h3A5, 1'b1);
    idle(10, 1'b1);
    chk("s30_loads", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("s30_data", 32'(log_q[0]), 32'h3A512);

    // Duplicate suppression and ordering
    do_reset();
    cyc(1'b1, 8'h12, 12'h3A5, 1'b1);
    cyc(1'b1, 8'h12, 12'h3A5, 1'b1);
    cyc(1'b1, 8'h13, 12'h3A5, 1'b1);
    idle(30, 1'b1);
    chk("s31_dup", 32'(bus.dup_cnt), 32'd1);
    chk("s31_loads", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("s31_first", 32'(log_q[0]), 32'h3A512);
      chk("s31_second", 32'(log_q[1]), 32'h3A513);
    end

    // Overflow while stalled, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, 8'(8'h40 + i), 12'(12'h100 + i), 1'b0);
    chk("s32_level", 32'(bus.fifo_level), 32'(DEPTH));
    chk("s32_ovf", 32'(bus.overflow_cnt), 32'd3);
    idle(DEPTH * 10, 1'b1);
    chk("s32_loads", 32'(log_q.size()), 32'(DEPTH));
    for (int i = 0; i < log_q.size(); i++) begin
      chk("s32_order", 32'(log_q[i]), 32'({12'(12'h100 + i), 8'(8'h40 + i)}));
      if (i > 0) chk("s32_gap", 32'(log_t[i] - log_t[i-1] >= MIN_GAP), 32'd1);
    end

    // Push accepted on a full FIFO when the same edge issues
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h60 + i), 12'(12'h200 + i), 1'b0);
    while ((edge_n + 1) % 4 != 0) cyc(1'b0, 8'h00, 12'h000, 1'b1);
    cyc(1'b1, 8'hEE, 12'hEEE, 1'b1);
    chk("s33_load", 32'(bus.load_out), 32'd1);
    chk("s33_level", 32'(bus.fifo_level), 32'(DEPTH));
    chk("s33_ovf", 32'(bus.overflow_cnt), 32'd0);
    idle(DEPTH * 10, 1'b1);

    // Asynchronous reset with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 12'(12'h300 + i), 1'b0);
    #2;
    do_reset();
    idle(40, 1'b1);
    chk("s34_loads", 32'(log_q.size()), 32'd0);

    // Randomized traffic with a small candidate pool to provoke duplicates
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 12'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 7);
    end
    idle(DEPTH * 10, 1'b1);

    // Duplicate counter saturation
    do_reset();
    cyc(1'b1, 8'h55, 12'h555, 1'b0);
    for (int i = 0; i < 70000; i++) cyc(1'b1, 8'h55, 12'h555, 1'b0);
    chk("s35_dup_sat", 32'(bus.dup_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
